// File: rtl/shift_rotate_unit.sv
// -----------------------------------------------------------------------------
// shift_rotate_unit
// Iterative shift/rotate execution unit for the DataPath ALU. Supports SHR,
// SHRA, SHL, ROR and ROL, with a start/done handshake. In iterative mode up to
// STEP bit positions are processed per SHIFT cycle.
//
// Optional feature macro: SRU_FASTPATH_EN
//   defined   - a full barrel shift is evaluated at the accepting edge and the
//               unit goes straight to DONE (latency 1 edge, STEP ignored).
//   undefined - iterative mode only.
//
// Ports:
//   Clock      in   1        rising-edge system clock
//   Clear      in   1        asynchronous, active-high reset
//   start      in   1        request; sampled only in IDLE
//   op         in   3        000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL,
//                            101-111 pass-through
//   data_in    in   WIDTH    operand
//   shamt      in   SHAMT_W  shift amount (mod WIDTH by construction)
//   busy       out  1        high while in SHIFT or DONE
//   done       out  1        one-cycle pulse; result valid on that cycle
//   result     out  WIDTH    working register; held until next accepted start
//   carry_out  out  1        last bit shifted/rotated out
// -----------------------------------------------------------------------------
module shift_rotate_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic               Clock,
    input  logic               Clear,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               carry_out
);

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    // The remaining count never exceeds WIDTH-1, so a larger STEP behaves
    // exactly like WIDTH-1 and keeps the per-cycle amount inside SHAMT_W bits.
    localparam int STEP_C = (STEP >= WIDTH) ? (WIDTH - 1) : ((STEP < 1) ? 1 : STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [2:0]         op_r, op_nxt_s;
    logic [WIDTH-1:0]   result_r, result_nxt_s;
    logic [SHAMT_W-1:0] count_r, count_nxt_s;
    logic               carry_r, carry_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic [SHAMT_W-1:0] step_k_s;
    logic [WIDTH:0]     shift_s;
`ifdef SRU_FASTPATH_EN
    logic [WIDTH:0]     fast_s;
`endif

    // Apply an operation by k positions; returns {carry, value}. k==0 or a
    // pass code leaves the value untouched with carry 0.
    function automatic logic [WIDTH:0] apply_op(
        input logic [2:0]         f_op,
        input logic [WIDTH-1:0]   v,
        input logic [SHAMT_W-1:0] k
    );
        logic [WIDTH-1:0] r;
        logic             c;
        logic [WIDTH-1:0] hi_out;
        logic [WIDTH-1:0] lo_out;
        r      = v;
        c      = 1'b0;
        hi_out = {WIDTH{1'b0}};
        lo_out = {WIDTH{1'b0}};
        if (k == {SHAMT_W{1'b0}}) begin
            r = v;
            c = 1'b0;
        end else begin
            // Bit position WIDTH-k leaves last on a left move, k-1 on a right move.
            hi_out = v >> (WIDTH - int'(k));
            lo_out = v >> (int'(k) - 1);
            case (f_op)
                OP_SHR: begin
                    r = v >> k;
                    c = lo_out[0];
                end
                OP_SHRA: begin
                    r = $signed(v) >>> k;
                    c = lo_out[0];
                end
                OP_SHL: begin
                    r = v << k;
                    c = hi_out[0];
                end
                OP_ROR: begin
                    r = (v >> k) | (v << (WIDTH - int'(k)));
                    c = lo_out[0];
                end
                OP_ROL: begin
                    r = (v << k) | (v >> (WIDTH - int'(k)));
                    c = hi_out[0];
                end
                default: begin
                    r = v;
                    c = 1'b0;
                end
            endcase
        end
        return {c, r};
    endfunction

    // Next-state and next-datapath computation for the control FSM.
    always_comb begin
        state_nxt_s  = state_r;
        op_nxt_s     = op_r;
        result_nxt_s = result_r;
        count_nxt_s  = count_r;
        carry_nxt_s  = carry_r;
        step_k_s     = (int'(count_r) < STEP_C) ? count_r : SHAMT_W'(STEP_C);
        shift_s      = apply_op(op_r, result_r, step_k_s);
`ifdef SRU_FASTPATH_EN
        fast_s       = apply_op(op, data_in, shamt);
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    op_nxt_s = op;
`ifdef SRU_FASTPATH_EN
                    result_nxt_s = fast_s[WIDTH-1:0];
                    carry_nxt_s  = fast_s[WIDTH];
                    count_nxt_s  = {SHAMT_W{1'b0}};
                    state_nxt_s  = ST_DONE;
`else
                    result_nxt_s = data_in;
                    carry_nxt_s  = 1'b0;
                    count_nxt_s  = shamt;
                    if ((shamt == {SHAMT_W{1'b0}}) || (op > OP_ROL)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                result_nxt_s = shift_s[WIDTH-1:0];
                carry_nxt_s  = shift_s[WIDTH];
                count_nxt_s  = count_r - step_k_s;
                if (count_r == step_k_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        // Flags are derived from the next state so they can be registered.
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_r  <= ST_IDLE;
            op_r     <= 3'b000;
            result_r <= {WIDTH{1'b0}};
            count_r  <= {SHAMT_W{1'b0}};
            carry_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            op_r     <= op_nxt_s;
            result_r <= result_nxt_s;
            count_r  <= count_nxt_s;
            carry_r  <= carry_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign carry_out = carry_r;

endmodule
